// File: rtl/chu_vga_sprite_array_core_if.sv
`default_nettype none
// ============================================================================
// Module      : chu_vga_sprite_array_core_if
// Description : Write-only slot bus for the multi-sprite video core.
// Revision    : 1.0 - initial release
// ============================================================================
interface chu_vga_sprite_array_core_if;
    logic        cs;
    logic        write;
    logic [13:0] addr;
    logic [31:0] wr_data;

    modport master (output cs, output write, output addr, output wr_data);
    modport slave  (input  cs, input  write, input  addr, input  wr_data);
endinterface
`default_nettype wire

// File: rtl/chu_vga_sprite_array_core.sv
`default_nettype none
// ============================================================================
// Module      : chu_vga_sprite_array_core
// Description : Overlays NS prioritised sprites from a shared image RAM onto
//               the pixel stream with a fixed 2-cycle latency.
// Revision    : 1.0 - initial release
// ============================================================================
module chu_vga_sprite_array_core #(
    parameter int CD        = 12,
    parameter int NS        = 4,
    parameter int SW        = 32,
    parameter int SH        = 32,
    parameter int NIMG      = 4,
    parameter int KEY_COLOR = 0,
    parameter int HMAX      = 640,
    parameter int VMAX      = 480
) (
    input  wire logic                   clk,
    input  wire logic                   reset,
    input  wire logic [10:0]            x_i,
    input  wire logic [10:0]            y_i,
    chu_vga_sprite_array_core_if.slave  bus,
    input  wire logic [CD-1:0]          si_rgb_i,
    output logic      [CD-1:0]          so_rgb_o
);
    localparam int c_XW    = $clog2(SW);
    localparam int c_YW    = $clog2(SH);
    localparam int c_IMG_W = (NIMG > 1) ? $clog2(NIMG) : 1;
    localparam int c_DEPTH = NIMG * SW * SH;
    localparam int c_AW    = $clog2(c_DEPTH);

    // Bus decode
    logic w_wr, w_ram_we, w_reg_we, w_glb_we, w_commit;
    assign w_wr     = bus.cs & bus.write;
    assign w_ram_we = w_wr & bus.addr[13];
    assign w_reg_we = w_wr & ~bus.addr[13] & ~bus.addr[6] & ~bus.addr[2];
    assign w_glb_we = w_wr & ~bus.addr[13] & bus.addr[6] & (bus.addr[1:0] == 2'b00);

    logic layer_en_q, imm_q;
    logic [10:0]        sh_x_q   [NS];
    logic [10:0]        sh_y_q   [NS];
    logic               sh_en_q  [NS];
    logic               sh_flip_q[NS];
    logic [c_IMG_W-1:0] sh_img_q [NS];
    logic [10:0]        act_x_q   [NS];
    logic [10:0]        act_y_q   [NS];
    logic               act_en_q  [NS];
    logic               act_flip_q[NS];
    logic [c_IMG_W-1:0] act_img_q [NS];

    assign w_commit = imm_q | ((x_i == 11'(HMAX - 1)) && (y_i == 11'(VMAX - 1)));

    // Active copies load the pre-edge shadow, so a same-edge write waits a frame
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            layer_en_q <= 1'b0;
            imm_q      <= 1'b0;
            for (int i = 0; i < NS; i++) begin
                sh_x_q[i]     <= '0;
                sh_y_q[i]     <= '0;
                sh_en_q[i]    <= 1'b0;
                sh_flip_q[i]  <= 1'b0;
                sh_img_q[i]   <= '0;
                act_x_q[i]    <= '0;
                act_y_q[i]    <= '0;
                act_en_q[i]   <= 1'b0;
                act_flip_q[i] <= 1'b0;
                act_img_q[i]  <= '0;
            end
        end else begin
            if (w_glb_we) begin
                layer_en_q <= bus.wr_data[0];
                imm_q      <= bus.wr_data[1];
            end
            for (int i = 0; i < NS; i++) begin
                if (w_reg_we && (bus.addr[5:3] == 3'(i))) begin
                    case (bus.addr[1:0])
                        2'd0: sh_x_q[i] <= bus.wr_data[10:0];
                        2'd1: sh_y_q[i] <= bus.wr_data[10:0];
                        2'd2: begin
                            sh_en_q[i]   <= bus.wr_data[0];
                            sh_flip_q[i] <= bus.wr_data[1];
                            sh_img_q[i]  <= bus.wr_data[c_IMG_W+1:2];
                        end
                        default: ;
                    endcase
                end
                if (w_commit) begin
                    act_x_q[i]    <= sh_x_q[i];
                    act_y_q[i]    <= sh_y_q[i];
                    act_en_q[i]   <= sh_en_q[i];
                    act_flip_q[i] <= sh_flip_q[i];
                    act_img_q[i]  <= sh_img_q[i];
                end
            end
        end
    end

    // 12-bit differences keep positions near 2047 from wrapping to the left/top
    logic [11:0] w_dx [NS];
    logic [11:0] w_dy [NS];
    logic        w_hit[NS];
    for (genvar g = 0; g < NS; g++) begin : g_hit
        assign w_dx[g]  = {1'b0, x_i} - {1'b0, act_x_q[g]};
        assign w_dy[g]  = {1'b0, y_i} - {1'b0, act_y_q[g]};
        assign w_hit[g] = act_en_q[g] && (w_dx[g] < 12'(SW)) && (w_dy[g] < 12'(SH));
    end

    logic               w_hit_any, w_flip_win;
    logic [c_XW-1:0]    w_dx_win, w_col;
    logic [c_YW-1:0]    w_dy_win;
    logic [c_IMG_W-1:0] w_img_win;
    logic [c_AW-1:0]    w_raddr;

    // Scan from the lowest priority upward so sprite 0 is assigned last
    always_comb begin
        w_hit_any  = 1'b0;
        w_flip_win = 1'b0;
        w_dx_win   = '0;
        w_dy_win   = '0;
        w_img_win  = '0;
        for (int i = NS - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_hit_any  = 1'b1;
                w_flip_win = act_flip_q[i];
                w_dx_win   = w_dx[i][c_XW-1:0];
                w_dy_win   = w_dy[i][c_YW-1:0];
                w_img_win  = act_img_q[i];
            end
        end
    end

    assign w_col   = w_flip_win ? (c_XW'(SW - 1) - w_dx_win) : w_dx_win;
    assign w_raddr = c_AW'({w_img_win, w_dy_win, w_col});

    logic [CD-1:0] mem [c_DEPTH];
    logic [CD-1:0] ram_rd_q;

    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            mem[bus.addr[c_AW-1:0]] <= bus.wr_data[CD-1:0];
        end
        ram_rd_q <= mem[w_raddr];
    end

    logic          hit_d1_q;
    logic [CD-1:0] si_d1_q, so_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_d1_q <= 1'b0;
            si_d1_q  <= '0;
            so_q     <= '0;
        end else begin
            hit_d1_q <= w_hit_any;
            si_d1_q  <= si_rgb_i;
            so_q     <= (layer_en_q && hit_d1_q && (ram_rd_q != CD'(KEY_COLOR))) ? ram_rd_q : si_d1_q;
        end
    end

    assign so_rgb_o = so_q;

    logic w_unused;
    assign w_unused = ^{bus.addr, bus.wr_data};
endmodule
`default_nettype wire

// File: doc/chu_vga_sprite_array_core.md
# chu_vga_sprite_array_core

Parametrised multi-sprite video core for the daisy-chained video pipeline. It overlays up to NS independently positioned sprites on the incoming pixel stream, all drawn from one shared image RAM holding NIMG sprite images. Each sprite has its own position, image select, horizontal flip and enable. Position and control updates are double-buffered and committed at the frame boundary. It occupies one video slot and is a drop-in replacement for a single-sprite core, keeping the same 2-cycle pixel latency.

## Interface
Parameters:
- CD, 12, color depth (bits per pixel)
- NS, 4, number of sprites, 1..8; index 0 has highest priority
- SW, 32, sprite width in pixels, power of two
- SH, 32, sprite height in pixels, power of two
- NIMG, 4, images in RAM, power of two; NIMG*SW*SH ≤ 8192
- KEY_COLOR, 0, transparent pixel value
- HMAX, 640, active width
- VMAX, 480, active height

Ports:
- clk  in  1  system clock; single clock domain
- reset  in  1  asynchronous, active-high reset
- x  in  11  current pixel column from frame counter
- y  in  11  current pixel row from frame counter
- cs  in  1  slot select
- write  in  1  write strobe, qualified by cs
- addr  in  14  slot register/memory word address
- wr_data  in  32  write data
- si_rgb  in  CD  upstream pixel
- so_rgb  out  CD  downstream pixel

## Operation
- All bus accesses are writes; there is no read path.
- Image RAM write (cs & write & addr[13]=1):
  - RAM word address {img, row, col} = addr[12:0], low log2(NIMG*SW*SH) bits.
  - Data is wr_data[CD-1:0].
  - RAM is synchronous single-write/single-read, not cleared by reset.
- Sprite register write (addr[13]=0, addr[6]=0):
  - Sprite s = addr[5:3]; writes to s ≥ NS are ignored.
  - Register offset addr[1:0]; offset 3 and addr[2]=1 are ignored.
  - Offset 0: shadow X, wr_data[10:0].
  - Offset 1: shadow Y, wr_data[10:0].
  - Offset 2: shadow control: bit0 enable, bit1 hflip, bits[log2 NIMG+1:2] image index.
- Global register write (addr[13]=0, addr[6]=1, addr[1:0]=0):
  - bit0 layer_en: 0 forces pass-through.
  - bit1 immediate: 1 makes shadow registers copy into active registers every clock.
- Commit, frame-synchronous mode (immediate=0): all active registers load from shadow on the rising edge where x==HMAX-1 and y==VMAX-1.
  - Pixel (HMAX-1, VMAX-1) is evaluated with the pre-commit values.
  - A write on the same edge lands in shadow and commits at the next frame boundary, not this one.
- Hit test per sprite, combinational in stage 1:
  - dx = {1'b0,x} − {1'b0,X}, dy = {1'b0,y} − {1'b0,Y}, both 12-bit two's complement.
  - Hit when enable & dx∈[0,SW) & dy∈[0,SH).
  - Positions near 2047 never wrap onto the left or top edges.
- Priority: the lowest-index hitting sprite wins. Only the winner is looked up.
  - A KEY_COLOR pixel of the winner shows si_rgb, never a lower-priority sprite.
- Column = hflip ? SW−1−dx : dx. Row = dy.

## Timing
- Fixed 2-cycle latency from x/y/si_rgb to so_rgb, unconditionally (hit or miss, any mode).
- Stage 1 register: hit_any, RAM address, si_rgb_d1. The RAM read is issued at this edge.
- Stage 2 register: so_rgb = (layer_en & hit_any_d & ram_q≠KEY_COLOR) ? ram_q : si_rgb_d2.
- Reset (async) sets to 0: all shadow/active registers, layer_en, immediate, pipeline registers and so_rgb. After release the output is pass-through with 2-cycle latency.
- Reset asserted mid-frame clears registers immediately. The RAM keeps its contents.
- RAM write/read collision at the same address returns old data. Sprites show it for one pixel only.
- x/y may be held constant for many cycles (inc low): the output simply repeats, and the commit condition may hold repeatedly, which is idempotent.

## Test plan
- Reset, then drive si_rgb=12'h123 at x=10,y=10 → so_rgb=12'h123 exactly 2 clocks later; so_rgb=0 while reset is high.
- Load image 1 with solid 12'hF00, sprite0 X=100,Y=50, img=1, enable, layer_en=1, immediate=1 → pixel (100,50) red, (131,81) red, (132,50) and (99,50) pass si_rgb.
- Sprite0 (img red) and sprite1 (img green) both at (200,200) → green never appears. Set image-1 pixel (0,0) to KEY_COLOR → pixel (200,200) shows si_rgb.
- Image with column gradient, hflip=1, X=0 → pixel x=0 shows column SW−1 color.
- Frame-synchronous mode: write X=300 mid-frame → rest of frame still at old X. From the first pixel after (639,479), sprite appears at 300.
- Sprite at X=2040,Y=470 → no hit at x=0..7 (no wrap). Writes to sprite index ≥ NS leave output unchanged.
